// File: rtl/cpu_pkg.sv
// Shared definitions for the small CPU slice (instruction fetch/loader, core,
// and benches).
//   fetch_state_t : loader FSM states
//   INS_W/OP_W/IMM_W : instruction layout {op[7:4], imm[3:0]}
//   NOP_INS       : instruction returned for unloaded or out-of-range fetches
package cpu_pkg;

  localparam int INS_W = 8;
  localparam int OP_W  = 4;
  localparam int IMM_W = 4;

  localparam logic [INS_W-1:0] NOP_INS = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_store.sv
// Instruction store: DEPTH x INS_W array with a synchronous write port and an
// asynchronous read port. Contents are not reset; the loader hides stale data
// by gating reads with its valid-instruction count.
//   clk   : write clock, rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module instr_store #(
  parameter int ADDR_W = 8,
  parameter int INS_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [INS_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [INS_W-1:0]  rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [INS_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_loader.sv
// Instruction fetch/loader. Fills the instruction store from a byte stream,
// then serves the core's instruction fetches and releases the core from reset.
//   clk        : system clock, rising edge
//   CLB        : asynchronous active-low reset
//   load_start : pulse to begin a new program load (ignored while loading)
//   load_valid : load_data valid
//   load_data  : instruction byte, written in address order from 0
//   load_last  : marks the final byte of the program
//   load_ready : loader can accept a byte
//   pc         : program counter from the core
//   input_ins  : instruction at pc (combinational), FILL_INS when not running
//                or when pc is beyond the loaded program
//   core_run   : 1 = core released from reset (only in RUN)
//   load_count : number of valid instructions stored
//   load_err   : sticky overflow flag, cleared by the next load_start
//   fsm_state  : current FSM state (fetch_state_t encoding) for observation
//
// Handshake: a byte transfers on a rising edge where load_valid and
// load_ready are both 1. While load_valid=1 and load_ready=0 the source holds
// load_data/load_last stable; load_last only counts on a transfer.
module instr_fetch_loader #(
  parameter int ADDR_W = 8,
  parameter int INS_W  = cpu_pkg::INS_W,
  parameter logic [INS_W-1:0] FILL_INS = cpu_pkg::NOP_INS
) (
  input  logic              clk,
  input  logic              CLB,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [INS_W-1:0]  load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic [7:0]        pc,
  output logic [INS_W-1:0]  input_ins,
  output logic              core_run,
  output logic [ADDR_W:0]   load_count,
  output logic              load_err,
  output logic [1:0]        fsm_state
);

  import cpu_pkg::*;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_P   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

  fetch_state_t     state, state_nx;
  logic [ADDR_W:0]  wr_ptr, wr_ptr_nx;
  logic [ADDR_W:0]  count_nx;
  logic             err_nx;
  logic             we;
  logic             xfer;
  logic             rd_hit;
  logic [INS_W-1:0] rdata;

  // wr_ptr is one bit wider than the address so it can sit at DEPTH after
  // the final slot is written; load_ready then stays low.
  assign load_ready = (state == LOAD) && (wr_ptr < DEPTH_P);
  assign xfer       = load_valid && load_ready;
  assign core_run   = (state == RUN);
  assign fsm_state  = state;

  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      load_count <= '0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      wr_ptr     <= wr_ptr_nx;
      load_count <= count_nx;
      load_err   <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    wr_ptr_nx = wr_ptr;
    count_nx  = load_count;
    err_nx    = load_err;
    we        = 1'b0;
    case (state)
      LOAD: begin
        if (xfer) begin
          we        = 1'b1;
          wr_ptr_nx = wr_ptr + 1'b1;
          count_nx  = wr_ptr + 1'b1;
          if (load_last) begin
            state_nx = RUN;
          end else if (wr_ptr == LAST_ADDR) begin
            // Store is full and the program has not ended: keep the byte,
            // flag the overflow and hold the core.
            state_nx = ERR;
            err_nx   = 1'b1;
          end
        end
      end
      IDLE, RUN, ERR: begin
        if (load_start) begin
          state_nx  = LOAD;
          wr_ptr_nx = '0;
          count_nx  = '0;
          err_nx    = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  instr_store #(
    .ADDR_W (ADDR_W),
    .INS_W  (INS_W)
  ) u_store (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (load_data),
    .raddr (pc[ADDR_W-1:0]),
    .rdata (rdata)
  );

  // load_count never exceeds DEPTH, so pc < load_count also rules out
  // pc >= DEPTH and the truncated read address cannot alias.
  assign rd_hit    = (state == RUN) && (32'(pc) < 32'(load_count));
  assign input_ins = rd_hit ? rdata : FILL_INS;

endmodule

// File: tb/tb_instr_fetch_loader.sv
// Directed bench for instr_fetch_loader: a full-size instance (ADDR_W=8) and
// a small instance (ADDR_W=2) used for overflow.
module tb_instr_fetch_loader;

  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic CLB = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A (ADDR_W=8) ----------------
  logic       a_start = 0, a_valid = 0, a_last = 0;
  logic [7:0] a_data = '0, a_pc = '0;
  logic       a_ready, a_run, a_err;
  logic [7:0] a_ins;
  logic [8:0] a_count;
  logic [1:0] a_state;

  instr_fetch_loader #(.ADDR_W(8)) dut_a (
    .clk(clk), .CLB(CLB), .load_start(a_start), .load_valid(a_valid),
    .load_data(a_data), .load_last(a_last), .load_ready(a_ready),
    .pc(a_pc), .input_ins(a_ins), .core_run(a_run), .load_count(a_count),
    .load_err(a_err), .fsm_state(a_state)
  );

  // ---------------- instance B (ADDR_W=2) ----------------
  logic       b_start = 0, b_valid = 0, b_last = 0;
  logic [7:0] b_data = '0, b_pc = '0;
  logic       b_ready, b_run, b_err;
  logic [7:0] b_ins;
  logic [2:0] b_count;
  logic [1:0] b_state;

  instr_fetch_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .CLB(CLB), .load_start(b_start), .load_valid(b_valid),
    .load_data(b_data), .load_last(b_last), .load_ready(b_ready),
    .pc(b_pc), .input_ins(b_ins), .core_run(b_run), .load_count(b_count),
    .load_err(b_err), .fsm_state(b_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All driving happens 1 time unit after a rising edge; checks follow after
  // another 1 unit so combinational outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_pulse_start();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic a_send(input logic [7:0] d, input logic last);
    a_valid = 1'b1; a_data = d; a_last = last;
    tick();
    a_valid = 1'b0; a_last = 1'b0;
  endtask

  task automatic b_send(input logic [7:0] d, input logic last);
    b_valid = 1'b1; b_data = d; b_last = last;
    tick();
    b_valid = 1'b0; b_last = 1'b0;
  endtask

  // Read back pc = 0..n-1 against exp_q, then pc = n expecting the fill value.
  task automatic a_readback(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      a_pc = 8'(i);
      #1;
      chk($sformatf("%s_pc%0d", tag, i), {24'd0, a_ins}, {24'd0, exp_q[i]});
    end
    a_pc = 8'(n);
    #1;
    chk($sformatf("%s_pc%0d_fill", tag, n), {24'd0, a_ins}, {24'd0, NOP_INS});
    a_pc = 8'd0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    #2;
    chk("rst_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_run",   {31'd0, a_run},   32'd0);
    chk("rst_count", {23'd0, a_count}, 32'd0);
    chk("rst_err",   {31'd0, a_err},   32'd0);
    chk("rst_ins",   {24'd0, a_ins},   32'h00);
    chk("rst_state", {30'd0, a_state}, 32'(IDLE));
    @(negedge clk);
    CLB = 1'b1;
    tick();

    // 1. Basic load of 3 bytes
    a_pulse_start();
    chk("s1_state_load", {30'd0, a_state}, 32'(LOAD));
    chk("s1_ready",      {31'd0, a_ready}, 32'd1);
    a_pc = 8'd0;
    #1;
    chk("s1_ins_in_load", {24'd0, a_ins}, 32'h00);
    a_send(8'h15, 1'b0);
    a_send(8'h23, 1'b0);
    chk("s1_run_before_last", {31'd0, a_run}, 32'd0);
    a_send(8'h31, 1'b1);
    chk("s1_run_after_last", {31'd0, a_run},   32'd1);
    chk("s1_count",          {23'd0, a_count}, 32'd3);
    chk("s1_ready_run",      {31'd0, a_ready}, 32'd0);
    exp_q = '{8'h15, 8'h23, 8'h31};
    a_readback("s1");
    a_pc = 8'hFF;
    #1;
    chk("s1_pc_ff", {24'd0, a_ins}, 32'h00);
    a_pc = 8'd0;

    // 2. Reload from RUN with gaps and a stray load_last
    a_pulse_start();
    chk("s2_run_dropped", {31'd0, a_run},   32'd0);
    chk("s2_count_clr",   {23'd0, a_count}, 32'd0);
    a_send(8'h15, 1'b0);            // beat 1: transfer
    a_last = 1'b1;                  // beat 2: last without valid
    tick();
    a_last = 1'b0;
    chk("s2_last_no_xfer_state", {30'd0, a_state}, 32'(LOAD));
    chk("s2_last_no_xfer_count", {23'd0, a_count}, 32'd1);
    a_send(8'h23, 1'b0);            // beat 3: transfer
    a_start = 1'b1;                 // beat 4: gap, load_start ignored in LOAD
    tick();
    a_start = 1'b0;
    chk("s2_start_ignored", {23'd0, a_count}, 32'd2);
    a_send(8'h31, 1'b1);            // beat 5: final transfer
    chk("s2_run",   {31'd0, a_run},   32'd1);
    chk("s2_count", {23'd0, a_count}, 32'd3);
    a_readback("s2");

    // 4. Reload a single byte; old contents above it are hidden
    a_pulse_start();
    chk("s4_run_dropped", {31'd0, a_run}, 32'd0);
    a_send(8'hA0, 1'b1);
    chk("s4_count", {23'd0, a_count}, 32'd1);
    exp_q = '{8'hA0};
    a_readback("s4");

    // 3. Overflow on the 4-entry instance
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_send(8'h11, 1'b0);
    b_send(8'h22, 1'b0);
    b_send(8'h33, 1'b0);
    chk("s3_ready_3", {31'd0, b_ready}, 32'd1);
    b_send(8'h44, 1'b0);
    chk("s3_err",   {31'd0, b_err},   32'd1);
    chk("s3_ready", {31'd0, b_ready}, 32'd0);
    chk("s3_run",   {31'd0, b_run},   32'd0);
    chk("s3_count", {29'd0, b_count}, 32'd4);
    chk("s3_state", {30'd0, b_state}, 32'(ERR));
    b_send(8'h55, 1'b1);            // valid in ERR: no effect
    chk("s3_err_sticky", {31'd0, b_err},   32'd1);
    chk("s3_ins_err",    {24'd0, b_ins},   32'h00);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("s3_err_clr",   {31'd0, b_err},   32'd0);
    chk("s3_count_clr", {29'd0, b_count}, 32'd0);
    chk("s3_ready_new", {31'd0, b_ready}, 32'd1);
    b_send(8'h7C, 1'b1);
    b_pc = 8'd0;
    #1;
    chk("s3_pc0", {24'd0, b_ins}, 32'h7C);
    b_pc = 8'd1;
    #1;
    chk("s3_pc1_hidden", {24'd0, b_ins}, 32'h00);
    b_pc = 8'd4;
    #1;
    chk("s3_pc4_range", {24'd0, b_ins}, 32'h00);
    b_pc = 8'd0;

    // 5. Asynchronous reset in the middle of a load
    a_pulse_start();
    a_send(8'h5A, 1'b0);
    a_send(8'h6B, 1'b0);
    chk("s5_count_mid", {23'd0, a_count}, 32'd2);
    #2;                             // well away from any clock edge
    CLB = 1'b0;
    #1;
    chk("s5_ready", {31'd0, a_ready}, 32'd0);
    chk("s5_count", {23'd0, a_count}, 32'd0);
    chk("s5_run",   {31'd0, a_run},   32'd0);
    chk("s5_err",   {31'd0, a_err},   32'd0);
    chk("s5_state", {30'd0, a_state}, 32'(IDLE));
    chk("s5_ins",   {24'd0, a_ins},   32'h00);
    @(negedge clk);
    CLB = 1'b1;
    tick();
    // A full reload is needed; stale bytes beyond it stay hidden.
    a_pulse_start();
    a_send(8'hC3, 1'b1);
    exp_q = '{8'hC3};
    a_readback("s5_reload");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_loader.md
Name: instr_fetch_loader

Overview:
Upstream neighbour of `core`. Holds the program in an on-chip instruction store that is filled over a valid/ready byte stream. Drives `core.input_ins` from the core's `pc` output. Gates core execution through `core_run`: the top level ANDs it with `CLB` to form the core's reset, so the core starts at pc=0 only once a complete program is loaded.

Parameters:
ADDR_W, 8, instruction-store address width; DEPTH = 2**ADDR_W entries (ADDR_W ≤ 8)
INS_W, 8, instruction width ({op[7:4], imm[3:0]})
FILL_INS, 8'h00, instruction returned for any unloaded or out-of-range address

Ports:
clk  in  1  system clock, rising edge
CLB  in  1  asynchronous active-low reset
load_start  in  1  request a new program load (single-cycle pulse)
load_valid  in  1  load_data valid
load_data  in  INS_W  instruction byte, written in address order from 0
load_last  in  1  qualifies the final byte of the program
load_ready  out  1  loader can accept a byte
pc  in  8  program counter from core
input_ins  out  INS_W  instruction at pc, to core
core_run  out  1  1 = core released from reset
load_count  out  ADDR_W+1  number of valid instructions stored
load_err  out  1  sticky overflow flag

Behaviour:
- Reset (CLB=0, async):
  - state=IDLE; wr_ptr=0; load_count=0; load_err=0; core_run=0; load_ready=0.
  - Store array is not reset. Reads are gated by load_count, so stale data is never visible.
- States: IDLE, LOAD, RUN, ERR. core_run=1 only in RUN (registered state decode). load_ready=1 only in LOAD with wr_ptr<DEPTH.
- IDLE:
  - load_start → LOAD next edge; wr_ptr←0, load_count←0, load_err←0.
- LOAD:
  - Transfer = load_valid & load_ready. On a transfer: mem[wr_ptr]←load_data, wr_ptr←wr_ptr+1, load_count←wr_ptr+1.
  - load_valid without load_ready: nothing written; the source must hold its data.
  - Transfer with load_last=1 → RUN next edge. core_run rises the cycle after the last write.
  - load_last without a transfer is ignored.
  - load_start is ignored while in LOAD.
  - Transfer at wr_ptr=DEPTH-1 with load_last=0: the byte is written, then state → ERR, load_err←1, load_ready←0.
- RUN:
  - input_ins = (pc < load_count) ? mem[pc[ADDR_W-1:0]] : FILL_INS. Combinational, zero-cycle latency: the core samples it in the same cycle pc is presented.
  - pc ≥ DEPTH also returns FILL_INS.
  - load_start → LOAD next edge: core_run falls on that edge, load_count←0, wr_ptr←0.
- ERR:
  - core_run=0; load_err stays 1.
  - load_start → LOAD, which clears load_err.
- In every state except RUN: input_ins=FILL_INS.
- Reset mid-load: the load is discarded, load_count=0, core stays held. A full reload is required.
- No same-address read/write hazard exists: reads are only exposed in RUN, and writes occur only in LOAD.

Decomposition:
- Shared package `cpu_pkg`:
  - `fetch_state_t` enum {IDLE, LOAD, RUN, ERR}.
  - INS_W, OP_W=4, IMM_W=4, and the NOP/FILL_INS constant, also used by `core` and the bench.
- One sub-module, `instr_store`:
  - DEPTH×INS_W array, synchronous write (we, waddr, wdata), asynchronous read (raddr → rdata).
  - No reset.
- Top-level FSM, pointer, count and read-gating logic live in `instr_fetch_loader`.

Test Plan:
1. Reset, then load_start and 3 bytes 8'h15, 8'h23, 8'h31 with load_last on the 3rd → load_count=3; core_run=1 exactly one cycle after the 3rd write; with pc=0,1,2,3, input_ins=15,23,31,00.
2. Backpressure/gaps: load_valid toggled 1,0,1,0,1 over 5 cycles (last on the 3rd beat) → exactly 3 writes, same contents as scenario 1; load_last asserted while load_valid=0 causes no state change.
3. Overflow with ADDR_W=2: 4 bytes, none with load_last → after the 4th, load_err=1, load_ready=0, core_run=0; load_start then clears load_err and load_count=0.
4. Reload from RUN: program from scenario 1 running, pulse load_start → core_run=0 next edge; load 1 byte 8'hA0 with last → input_ins at pc=0 is A0, pc=1 is 00 (old 8'h23 hidden).
5. Async reset mid-load after 2 of 4 bytes → all outputs at reset values immediately (before the next clk edge); input_ins=00 for pc=0.
6. End-to-end with `core`: load a 10-instruction program, run the core under core_run&CLB → the `{acc,pc}` sequence matches the golden list each cycle.
